// File: rtl/alu_input_sequencer_pkg.sv
// Shared types for the ALU input sequencer: machine word, ALU opcodes and
// sequencer FSM states.
package alu_input_sequencer_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned FLAGS_W = 3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [OP_W-1:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7,
    ALU_NOR = 4'hC
  } aluop_t;

  typedef enum logic [STATE_W-1:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } seq_state_t;

  // Sign-extend the 16-bit switch value using the sign switch.
  function automatic word_t operand_of(input logic [16:0] sw_v);
    return {{16{sw_v[16]}}, sw_v[15:0]};
  endfunction

endpackage

// File: rtl/alu_input_sequencer_if.sv
// ALU bus between the sequencer (master) and the combinational ALU (slave).
//   porta, portb : operands driven by the sequencer
//   op           : ALU opcode driven by the sequencer
//   alu_out      : ALU result
//   alu_zf/nf/of : ALU zero / negative / overflow flags
interface alu_input_sequencer_if;
  import alu_input_sequencer_pkg::*;

  word_t  porta;
  word_t  portb;
  aluop_t op;
  word_t  alu_out;
  logic   alu_zf;
  logic   alu_nf;
  logic   alu_of;

  modport master (
    output porta, portb, op,
    input  alu_out, alu_zf, alu_nf, alu_of
  );

  modport slave (
    input  porta, portb, op,
    output alu_out, alu_zf, alu_nf, alu_of
  );
endinterface

// File: rtl/alu_input_sequencer_key_debounce.sv
// Synchronizes and debounces one active-low pushbutton.
//   CLK, RST : clock, synchronous active-high reset
//   raw_n    : raw active-low key
//   level    : accepted debounced level, 1 = pressed
//   press    : one-cycle pulse on accepted released->pressed transition
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_n,
  output logic level,
  output logic press
);
  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with the accepted level;
  // the level flips on the DEBOUNCE_CYCLES-th such sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= ~raw_n;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/alu_input_sequencer.sv
// Board front end for the ALU: debounced ENTER/CLEAR keys step through
// operand A, operand B and opcode entry, then latch the ALU result/flags.
//   CLK, RST : clock, synchronous active-high reset
//   key_n    : raw active-low keys, [0] ENTER, [3] CLEAR
//   sw       : raw switches, [15:0] value, [16] sign, [3:0] opcode
//   alu      : ALU bus (porta/portb/op out, alu_out/flags in)
//   result   : latched ALU result
//   flags    : latched {of, nf, zf}
//   valid    : result/flags hold a completed operation
//   state    : current FSM state
module alu_input_sequencer
  import alu_input_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          key_n,
  input  logic [17:0]         sw,
  alu_input_sequencer_if.master alu,
  output word_t               result,
  output logic [FLAGS_W-1:0]  flags,
  output logic                valid,
  output seq_state_t          state
);
  logic [16:0] sw_m;
  logic [16:0] sw_s;
  logic        enter_press;
  logic        clear_press;
  logic        enter_level_unused;
  logic        clear_level_unused;
  logic        unused_inputs;

  assign unused_inputs = &{1'b0, sw[17], key_n[2:1], enter_level_unused, clear_level_unused};

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .CLK   (CLK),
    .RST   (RST),
    .raw_n (key_n[0]),
    .level (enter_level_unused),
    .press (enter_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .CLK   (CLK),
    .RST   (RST),
    .raw_n (key_n[3]),
    .level (clear_level_unused),
    .press (clear_press)
  );

  // Two-flop synchronizer for the switch bank.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= sw[16:0];
      sw_s <= sw_m;
    end
  end

  // Entry sequencer; CLEAR takes priority over ENTER in every state.
  always_ff @(posedge CLK) begin
    if (RST || clear_press) begin
      alu.porta <= '0;
      alu.portb <= '0;
      alu.op    <= aluop_t'(OP_W'(0));
      result    <= '0;
      flags     <= '0;
      valid     <= 1'b0;
      state     <= LOAD_A;
    end else begin
      unique case (state)
        LOAD_A: begin
          if (enter_press) begin
            alu.porta <= operand_of(sw_s);
            valid     <= 1'b0;
            state     <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (enter_press) begin
            alu.portb <= operand_of(sw_s);
            state     <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (enter_press) begin
            alu.op <= aluop_t'(sw_s[OP_W-1:0]);
            state  <= EXEC;
          end
        end
        EXEC: begin
          result <= alu.alu_out;
          flags  <= {alu.alu_of, alu.alu_nf, alu.alu_zf};
          valid  <= 1'b1;
          state  <= SHOW;
        end
        SHOW: begin
          if (enter_press) begin
            state <= LOAD_A;
          end
        end
        default: begin
          state <= LOAD_A;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer with a small reference ALU on the bus.
module tb_alu_input_sequencer;
  import alu_input_sequencer_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  key_n = 4'hF;
  logic [17:0] sw = '0;
  word_t       result;
  logic [2:0]  flags;
  logic        valid;
  seq_state_t  state;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu_input_sequencer_if alu_bus ();

  alu_input_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .key_n  (key_n),
    .sw     (sw),
    .alu    (alu_bus),
    .result (result),
    .flags  (flags),
    .valid  (valid),
    .state  (state)
  );

  always #5 CLK = ~CLK;

  // Reference combinational ALU.
  always_comb begin
    alu_bus.alu_out = '0;
    alu_bus.alu_of  = 1'b0;
    case (alu_bus.op)
      ALU_AND: alu_bus.alu_out = alu_bus.porta & alu_bus.portb;
      ALU_OR:  alu_bus.alu_out = alu_bus.porta | alu_bus.portb;
      ALU_ADD: begin
        alu_bus.alu_out = alu_bus.porta + alu_bus.portb;
        alu_bus.alu_of  = (alu_bus.porta[31] == alu_bus.portb[31]) &&
                          (alu_bus.alu_out[31] != alu_bus.porta[31]);
      end
      ALU_SUB: begin
        alu_bus.alu_out = alu_bus.porta - alu_bus.portb;
        alu_bus.alu_of  = (alu_bus.porta[31] != alu_bus.portb[31]) &&
                          (alu_bus.alu_out[31] != alu_bus.porta[31]);
      end
      ALU_NOR: alu_bus.alu_out = ~(alu_bus.porta | alu_bus.portb);
      default: alu_bus.alu_out = '0;
    endcase
    alu_bus.alu_zf = (alu_bus.alu_out == '0);
    alu_bus.alu_nf = alu_bus.alu_out[31];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Clean ENTER press held for 'hold' cycles, then released and settled.
  task automatic enter(input int hold);
    @(negedge CLK) key_n[0] = 1'b0;
    repeat (hold) @(negedge CLK);
    key_n[0] = 1'b1;
    repeat (12) @(negedge CLK);
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge CLK);
    chk("rst_state", 32'(state), 32'(LOAD_A));
    chk("rst_porta", alu_bus.porta, 32'h0);
    chk("rst_portb", alu_bus.portb, 32'h0);
    chk("rst_op",    32'(alu_bus.op), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    RST = 1'b0;

    // 5 + 3 with exact ENTER-to-valid timing
    sw = 18'h00005;
    enter(10);
    chk("a_porta", alu_bus.porta, 32'h5);
    chk("a_state", 32'(state), 32'(LOAD_B));
    sw = 18'h00003;
    enter(10);
    chk("b_portb", alu_bus.portb, 32'h3);
    chk("b_state", 32'(state), 32'(LOAD_OP));
    sw = 18'(ALU_ADD);
    @(negedge CLK) key_n[0] = 1'b0;
    repeat (8) @(negedge CLK);
    chk("exec_state", 32'(state), 32'(EXEC));
    chk("exec_valid", 32'(valid), 32'h0);
    chk("exec_op", 32'(alu_bus.op), 32'(ALU_ADD));
    @(negedge CLK);
    chk("show_state", 32'(state), 32'(SHOW));
    chk("show_valid", 32'(valid), 32'h1);
    chk("show_result", result, 32'h8);
    chk("show_flags", 32'(flags), 32'h0);
    key_n[0] = 1'b1;
    repeat (12) @(negedge CLK);

    // Bounce shorter than the debounce window, then a long hold
    @(negedge CLK) key_n[0] = 1'b0;
    repeat (3) @(negedge CLK);
    key_n[0] = 1'b1;
    repeat (12) @(negedge CLK);
    chk("bounce_state", 32'(state), 32'(SHOW));
    enter(100);
    chk("hold_state", 32'(state), 32'(LOAD_A));
    chk("hold_valid", 32'(valid), 32'h1);
    chk("hold_result", result, 32'h8);

    // Reset during EXEC
    sw = 18'h00007;
    enter(10);
    sw = 18'h00002;
    enter(10);
    sw = 18'(ALU_SUB);
    @(negedge CLK) key_n[0] = 1'b0;
    repeat (8) @(negedge CLK);
    chk("rexec_state", 32'(state), 32'(EXEC));
    RST = 1'b1;
    @(negedge CLK);
    chk("rexec_after_state", 32'(state), 32'(LOAD_A));
    chk("rexec_result", result, 32'h0);
    chk("rexec_valid", 32'(valid), 32'h0);
    chk("rexec_porta", alu_bus.porta, 32'h0);
    key_n[0] = 1'b1;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    chk("rexec_idle", 32'(state), 32'(LOAD_A));

    // Sign-extended A = -1, B = 1, ADD -> 0 with zf
    sw = 18'h1FFFF;
    enter(10);
    chk("neg_porta", alu_bus.porta, 32'hFFFF_FFFF);
    sw = 18'h00001;
    enter(10);
    sw = 18'(ALU_ADD);
    enter(10);
    chk("neg_state", 32'(state), 32'(SHOW));
    chk("neg_result", result, 32'h0);
    chk("neg_flags", 32'(flags), 32'h1);
    chk("neg_valid", 32'(valid), 32'h1);

    // SHOW -> LOAD_A keeps valid until operand A is entered
    enter(10);
    chk("ret_state", 32'(state), 32'(LOAD_A));
    chk("ret_valid", 32'(valid), 32'h1);
    sw = 18'h00009;
    enter(10);
    chk("a2_porta", alu_bus.porta, 32'h9);
    chk("a2_valid", 32'(valid), 32'h0);
    sw = 18'h00004;
    enter(10);
    chk("b2_state", 32'(state), 32'(LOAD_OP));

    // ENTER and CLEAR together in LOAD_OP: CLEAR wins
    sw = 18'(ALU_OR);
    @(negedge CLK) key_n = 4'b0110;
    repeat (10) @(negedge CLK);
    key_n = 4'hF;
    repeat (12) @(negedge CLK);
    chk("clr_state", 32'(state), 32'(LOAD_A));
    chk("clr_porta", alu_bus.porta, 32'h0);
    chk("clr_portb", alu_bus.portb, 32'h0);
    chk("clr_op", 32'(alu_bus.op), 32'h0);
    chk("clr_valid", 32'(valid), 32'h0);
    chk("clr_flags", 32'(flags), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
